ahb_burst_master: RTL and testbench
===================================

# ahb_burst_master

AHB-Lite bus master that sits directly upstream of `ahb_slave` and drives its address/control and write-data inputs. It accepts one burst command at a time from a local command interface and issues it as a pipelined sequence of NONSEQ/SEQ beats. It honours `hready` wait states, returns read data beat by beat, and aborts the burst on an error response.

## Interface
- `INCR_MAX`, default 16: maximum beat count for undefined-length INCR bursts.
- `hclk` in 1: bus clock; every flop is on its rising edge.
- `hreset` in 1: **synchronous, active-high reset**; one clock domain only.
- `cmd_valid` in 1: command request.
- `cmd_ready` out 1: command accepted when `cmd_valid & cmd_ready`.
- `cmd_write` in 1: 1 = write, 0 = read.
- `cmd_addr` in 32: start byte address, word aligned (bits [1:0] ignored and driven 0).
- `cmd_burst` in 3: HBURST encoding.
- `cmd_len` in 5: INCR beat count minus 1; ignored for the other burst types.
- `wr_data` in 32: write data for the beat currently in its address phase.
- `wr_ack` out 1: `wr_data` was consumed this cycle.
- `rd_data` out 32: read data for the completed read beat.
- `rd_valid` out 1: `rd_data` is valid this cycle.
- `cmd_done` out 1: one-cycle pulse when the burst ends.
- `cmd_err` out 1: qualifies `cmd_done`; 1 means the burst was aborted by `hresp`.
- `haddr` out 32, `hwrite` out 1, `hsize` out 3, `hburst` out 3, `hprot` out 4, `htrans` out 2, `hmastlock` out 1, `hwdata` out 32: AHB master outputs.
- `hready` in 1: bus ready (the muxed slave `hreadyout`).
- `hresp` in 1: error response.
- `hrdata` in 32: read data from the slave.

## Operation
- Fixed outputs: `hsize` = 3'b010 (word), `hprot` = 4'b0011, `hmastlock` = 0.
- Beats per burst: SINGLE = 1, INCR = `cmd_len`+1, clamped to `INCR_MAX`; WRAP4/INCR4 = 4; WRAP8/INCR8 = 8; WRAP16/INCR16 = 16.
- Address step is +4.
  - INCR bursts: 32-bit wraparound.
  - WRAP bursts: let mask = beats*4−1; next = (addr & ~mask) | ((addr+4) & mask).
- State machine:
  - IDLE: `cmd_ready`=1, `htrans`=IDLE. On accept, latch the command and load `beats_left` = beats → ADDR.
  - ADDR: drive `htrans`=NONSEQ, `haddr`=start address.
    - If `hready`=1, the beat's address phase completes. If `beats_left`=1 → DLAST, else → SEQ.
    - If `hready`=0, hold all outputs.
  - SEQ: drive `htrans`=SEQ with the next address. On `hready`=1, advance; when the last beat's address phase is accepted → DLAST.
  - DLAST: `htrans`=IDLE. On `hready`=1 → IDLE, with `cmd_done` pulsing in the following cycle.
  - ERR: `htrans`=IDLE for one cycle, then → IDLE with `cmd_done`=1 and `cmd_err`=1.
- Write path:
  - On the cycle a write beat's address phase completes, register `hwdata` ← `wr_data` and pulse `wr_ack`.
  - `hwdata` holds until the next accepted beat.
- Read path: on the cycle a read data phase completes (data phase active and `hready`=1), drive `rd_valid`=1 and `rd_data`=`hrdata`.
- Error: `hresp`=1 during an active data phase, at any `hready`:
  - → ERR. Remaining beats are dropped and `htrans` is forced to IDLE next cycle.
  - No further `wr_ack` or `rd_valid` for that burst.
- `cmd_len` above `INCR_MAX`−1 is clamped; no error is flagged.

## Timing
- Command accepted at edge N. NONSEQ is on the bus in cycle N+1.
- With zero wait states, a burst of B beats occupies B address cycles plus 1 trailing data cycle. `cmd_done` pulses in cycle N+B+2.
- Throughput: one beat per cycle with zero wait states. Address phase of beat k overlaps the data phase of beat k−1.
- Back-to-back commands: at least one IDLE cycle between bursts (`cmd_ready` is high only in IDLE).
- `hready`=0: all AHB outputs are held stable, and `beats_left` and the address counter freeze.
- Reset, synchronous and taking priority over everything else, including mid-burst:
  - next edge → IDLE, with `htrans`=IDLE.
  - `haddr`, `hwdata`, `rd_data` = 0; `hwrite`, `hburst` = 0.
  - `wr_ack`, `rd_valid`, `cmd_done`, `cmd_err` = 0.
  - `cmd_ready`=0 while `hreset` is high.
  - In-flight beats are discarded without a `cmd_done`.

## Structure
- Shared package `ahb_pkg`:
  - HTRANS codes (IDLE 2'b00, BUSY 2'b01, NONSEQ 2'b10, SEQ 2'b11).
  - HBURST codes (SINGLE..INCR16).
  - HSIZE_WORD.
  - Master state enum.
  - `beats_of(hburst, len)` function.
- Sub-module `ahb_addr_gen`: combinational next-address from (addr, hburst, beats). Reused by `ahb_slave` burst address tracking.

## Test plan
- SINGLE write to 0x0000_0010, data 0xDEAD_BEEF, zero waits:
  - `htrans` = NONSEQ then IDLE.
  - `hwdata`=0xDEAD_BEEF in the data cycle.
  - `cmd_done`, `cmd_err`=0 at N+3.
- INCR4 read from 0x20: `haddr` = 0x20, 0x24, 0x28, 0x2C with NONSEQ, SEQ, SEQ, SEQ; 4 `rd_valid` pulses in address order.
- WRAP4 write from 0x38: `haddr` = 0x38, 0x3C, 0x30, 0x34; 4 `wr_ack` pulses.
- INCR8 read with `hready` low for 2 cycles on beat 3: all AHB outputs held for those cycles; `cmd_done` delayed by exactly 2 cycles.
- INCR16 write with `hresp`=1 on beat 5's data phase:
  - `htrans`=IDLE next cycle.
  - No further `wr_ack`.
  - `cmd_done` with `cmd_err`=1.
- `hreset` asserted mid-INCR8 read: next edge `htrans`=IDLE, outputs at reset values, no `cmd_done`; a new SINGLE command is accepted afterwards.

Source files
------------

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite definitions: transfer/burst codes, master state, command
// payload and burst beat-count helpers used by the master and slave blocks.
package ahb_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned LEN_W  = 5;
  // Beat counters must hold up to 32 beats (cmd_len is 5 bits).
  localparam int unsigned BEAT_W = 6;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'b000,
    HBURST_INCR   = 3'b001,
    HBURST_WRAP4  = 3'b010,
    HBURST_INCR4  = 3'b011,
    HBURST_WRAP8  = 3'b100,
    HBURST_INCR8  = 3'b101,
    HBURST_WRAP16 = 3'b110,
    HBURST_INCR16 = 3'b111
  } hburst_e;

  localparam logic [2:0] HSIZE_WORD = 3'b010;
  localparam logic [3:0] HPROT_DATA = 4'b0011;

  typedef enum logic [2:0] {
    MST_IDLE  = 3'd0,
    MST_ADDR  = 3'd1,
    MST_SEQ   = 3'd2,
    MST_DLAST = 3'd3,
    MST_ERR   = 3'd4
  } mst_state_e;

  // Local command payload as presented on the command interface.
  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [2:0]        burst;
    logic [LEN_W-1:0]  len;
  } ahb_cmd_t;

  // Beat count of a burst; INCR is len+1 before any INCR_MAX clamp.
  function automatic logic [BEAT_W-1:0] beats_of(input logic [2:0] hburst,
                                                 input logic [LEN_W-1:0] len);
    case (hburst)
      HBURST_SINGLE:               beats_of = BEAT_W'(1);
      HBURST_INCR:                 beats_of = BEAT_W'(len) + BEAT_W'(1);
      HBURST_WRAP4, HBURST_INCR4:  beats_of = BEAT_W'(4);
      HBURST_WRAP8, HBURST_INCR8:  beats_of = BEAT_W'(8);
      default:                     beats_of = BEAT_W'(16);
    endcase
  endfunction

  function automatic logic is_wrap(input logic [2:0] hburst);
    return hburst inside {HBURST_WRAP4, HBURST_WRAP8, HBURST_WRAP16};
  endfunction

endpackage

// File: rtl/ahb_addr_gen.sv
// Combinational next-beat address for word bursts.
//   addr        : current beat address (word aligned)
//   hburst      : HBURST code of the burst
//   beats       : total beats of the burst (sets the wrap boundary)
//   next_addr_c : address of the following beat
module ahb_addr_gen
  import ahb_pkg::*;
(
  input  logic [ADDR_W-1:0] addr,
  input  logic [2:0]        hburst,
  input  logic [BEAT_W-1:0] beats,
  output logic [ADDR_W-1:0] next_addr_c
);

  logic [ADDR_W-1:0] incr;
  logic [ADDR_W-1:0] mask;

  // Wrap bursts keep the bits above the burst span and wrap the rest.
  always_comb begin
    incr = addr + ADDR_W'(4);
    mask = ADDR_W'({beats, 2'b00}) - ADDR_W'(1);
    if (is_wrap(hburst)) begin
      next_addr_c = (addr & ~mask) | (incr & mask);
    end else begin
      next_addr_c = incr;
    end
  end

endmodule

// File: rtl/ahb_burst_master.sv
// AHB-Lite burst master: takes one local burst command at a time and issues it
// as pipelined NONSEQ/SEQ word beats, honouring wait states and error aborts.
//   hclk, hreset         : clock, synchronous active-high reset
//   cmd_*                : command handshake (cmd_ready is high only in IDLE)
//   wr_data / wr_ack     : write data for the beat in its address phase; wr_ack
//                          is high in the cycle that beat's address is accepted
//   rd_data / rd_valid   : read data, valid the cycle after its data phase ends
//   cmd_done / cmd_err   : end-of-burst pulse, err = aborted by hresp
//   h*                   : AHB-Lite master signals
module ahb_burst_master
  import ahb_pkg::*;
#(
  parameter int unsigned INCR_MAX = 16
) (
  input  logic              hclk,
  input  logic              hreset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [2:0]        cmd_burst,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              cmd_done,
  output logic              cmd_err,
  output logic [ADDR_W-1:0] haddr,
  output logic              hwrite,
  output logic [2:0]        hsize,
  output logic [2:0]        hburst,
  output logic [3:0]        hprot,
  output logic [1:0]        htrans,
  output logic              hmastlock,
  output logic [DATA_W-1:0] hwdata,
  input  logic              hready,
  input  logic              hresp,
  input  logic [DATA_W-1:0] hrdata
);

  mst_state_e        state_q, state_d;
  logic [BEAT_W-1:0] beats_left_q, beats_left_d;
  logic [BEAT_W-1:0] beats_tot_q, beats_tot_d;
  logic [BEAT_W-1:0] beats_cmd;
  logic [ADDR_W-1:0] next_addr_c;
  logic [ADDR_W-1:0] haddr_d;
  logic [DATA_W-1:0] hwdata_d, rd_data_d;
  logic [2:0]        hburst_d;
  logic [1:0]        htrans_d;
  logic              hwrite_d, rd_valid_d, cmd_done_d, cmd_err_d;
  logic              addr_adv, rd_done, wr_ack_c;
  ahb_cmd_t          cmd_in;
  logic [1:0]        unused_addr_lsb;

  assign hsize     = HSIZE_WORD;
  assign hprot     = HPROT_DATA;
  assign hmastlock = 1'b0;

  assign cmd_in = '{write: cmd_write, addr: {cmd_addr[ADDR_W-1:2], 2'b00},
                    burst: cmd_burst, len: cmd_len};
  assign unused_addr_lsb = cmd_addr[1:0];

  assign cmd_ready = (state_q == MST_IDLE) && !hreset;
  assign wr_ack    = wr_ack_c && !hreset;

  ahb_addr_gen u_addr_gen (
    .addr        (haddr),
    .hburst      (hburst),
    .beats       (beats_tot_q),
    .next_addr_c (next_addr_c)
  );

  // Clamp undefined-length INCR bursts to INCR_MAX beats.
  always_comb begin
    beats_cmd = beats_of(cmd_in.burst, cmd_in.len);
    if (cmd_in.burst == HBURST_INCR && beats_cmd > BEAT_W'(INCR_MAX)) begin
      beats_cmd = BEAT_W'(INCR_MAX);
    end
  end

  // Next-state and next-output logic; registered outputs hold by default.
  always_comb begin
    state_d      = state_q;
    beats_left_d = beats_left_q;
    beats_tot_d  = beats_tot_q;
    haddr_d      = haddr;
    hwrite_d     = hwrite;
    hburst_d     = hburst;
    htrans_d     = htrans;
    hwdata_d     = hwdata;
    rd_data_d    = rd_data;
    rd_valid_d   = 1'b0;
    cmd_done_d   = 1'b0;
    cmd_err_d    = 1'b0;
    wr_ack_c     = 1'b0;
    addr_adv     = 1'b0;
    rd_done      = 1'b0;

    case (state_q)
      MST_IDLE: begin
        htrans_d = HTRANS_IDLE;
        if (cmd_valid && cmd_ready) begin
          haddr_d      = cmd_in.addr;
          hwrite_d     = cmd_in.write;
          hburst_d     = cmd_in.burst;
          beats_left_d = beats_cmd;
          beats_tot_d  = beats_cmd;
          htrans_d     = HTRANS_NONSEQ;
          state_d      = MST_ADDR;
        end
      end
      MST_ADDR: begin
        addr_adv = hready;
      end
      MST_SEQ: begin
        // An error on the previous beat's data phase cancels this address.
        if (hresp) begin
          htrans_d = HTRANS_IDLE;
          state_d  = MST_ERR;
        end else begin
          addr_adv = hready;
          rd_done  = hready;
        end
      end
      MST_DLAST: begin
        if (hresp) begin
          state_d = MST_ERR;
        end else if (hready) begin
          rd_done    = 1'b1;
          cmd_done_d = 1'b1;
          state_d    = MST_IDLE;
        end
      end
      MST_ERR: begin
        htrans_d   = HTRANS_IDLE;
        cmd_done_d = 1'b1;
        cmd_err_d  = 1'b1;
        state_d    = MST_IDLE;
      end
      default: begin
        htrans_d = HTRANS_IDLE;
        state_d  = MST_IDLE;
      end
    endcase

    // Address phase accepted: capture write data and move to the next beat.
    if (addr_adv) begin
      wr_ack_c     = hwrite;
      beats_left_d = beats_left_q - BEAT_W'(1);
      if (hwrite) begin
        hwdata_d = wr_data;
      end
      if (beats_left_q == BEAT_W'(1)) begin
        htrans_d = HTRANS_IDLE;
        state_d  = MST_DLAST;
      end else begin
        haddr_d  = next_addr_c;
        htrans_d = HTRANS_SEQ;
        state_d  = MST_SEQ;
      end
    end

    // Data phase completed for a read beat.
    if (rd_done && !hwrite) begin
      rd_valid_d = 1'b1;
      rd_data_d  = hrdata;
    end
  end

  // State and output registers.
  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q      <= MST_IDLE;
      beats_left_q <= '0;
      beats_tot_q  <= '0;
      haddr        <= '0;
      hwrite       <= 1'b0;
      hburst       <= 3'b000;
      htrans       <= HTRANS_IDLE;
      hwdata       <= '0;
      rd_data      <= '0;
      rd_valid     <= 1'b0;
      cmd_done     <= 1'b0;
      cmd_err      <= 1'b0;
    end else begin
      state_q      <= state_d;
      beats_left_q <= beats_left_d;
      beats_tot_q  <= beats_tot_d;
      haddr        <= haddr_d;
      hwrite       <= hwrite_d;
      hburst       <= hburst_d;
      htrans       <= htrans_d;
      hwdata       <= hwdata_d;
      rd_data      <= rd_data_d;
      rd_valid     <= rd_valid_d;
      cmd_done     <= cmd_done_d;
      cmd_err      <= cmd_err_d;
    end
  end

endmodule

// File: tb/tb_ahb_burst_master.sv
// Directed bench for ahb_burst_master: a table of burst commands with
// hand-computed beat counts, key addresses and completion cycles, driven
// against a small reactive slave, plus a mid-burst reset sequence.
module tb_ahb_burst_master;

  logic        hclk;
  logic        hreset;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr;
  logic [2:0]  cmd_burst;
  logic [4:0]  cmd_len;
  logic [31:0] wr_data, rd_data, hrdata, haddr, hwdata;
  logic        wr_ack, rd_valid, cmd_done, cmd_err;
  logic        hwrite, hmastlock, hready, hresp;
  logic [2:0]  hsize, hburst;
  logic [3:0]  hprot;
  logic [1:0]  htrans;

  int n_checks = 0;
  int n_fail   = 0;

  ahb_burst_master #(.INCR_MAX(16)) dut (
    .hclk(hclk), .hreset(hreset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_burst(cmd_burst), .cmd_len(cmd_len),
    .wr_data(wr_data), .wr_ack(wr_ack), .rd_data(rd_data), .rd_valid(rd_valid),
    .cmd_done(cmd_done), .cmd_err(cmd_err),
    .haddr(haddr), .hwrite(hwrite), .hsize(hsize), .hburst(hburst),
    .hprot(hprot), .htrans(htrans), .hmastlock(hmastlock), .hwdata(hwdata),
    .hready(hready), .hresp(hresp), .hrdata(hrdata)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [2:0]  burst;
    logic [4:0]  len;
    int          stall_beat;
    int          stall_n;
    int          err_beat;
    logic [31:0] wd0;
    int          exp_beats;
    logic [31:0] exp_a1;
    logic [31:0] exp_last;
    int          exp_done;
    logic        exp_err;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rd_f(input logic [31:0] a);
    return a ^ 32'h5A5A_A5A5;
  endfunction

  // Reference beat address: wrap bursts step modulo the burst span.
  function automatic logic [31:0] tb_addr(input logic [31:0] start, input logic [2:0] b, input int i);
    logic [31:0] s, span, base;
    s = {start[31:2], 2'b00};
    case (b)
      3'd2:    span = 32'd16;
      3'd4:    span = 32'd32;
      3'd6:    span = 32'd64;
      default: span = 32'd0;
    endcase
    if (span != 0) begin
      base = s - (s % span);
      return base + (((s - base) + 32'(4 * i)) % span);
    end
    return s + 32'(4 * i);
  endfunction

  task automatic do_burst(input vec_t v, input int rst_cyc);
    logic [31:0] addrs[$];
    int acc, rdn, ackn, done_cyc;
    logic done_seen, done_err, dp_active, err_sent, addr_ph, bad;
    logic [31:0] dp_addr, wd_exp, p_haddr, p_hwdata;
    int dp_beat, stalls;
    logic prev_hready, prev_hresp, exp_idle, wd_pending, p_hwrite;
    logic [1:0] p_htrans;
    logic [2:0] p_hburst;
    acc = 0; rdn = 0; ackn = 0; done_cyc = 0; dp_beat = 0; stalls = 0;
    done_seen = 0; done_err = 0; dp_active = 0; err_sent = 0; bad = 0;
    dp_addr = 0; wd_exp = 0; p_haddr = 0; p_hwdata = 0; p_hwrite = 0;
    p_htrans = 0; p_hburst = 0; prev_hready = 1; prev_hresp = 0;
    exp_idle = 0; wd_pending = 0;

    @(negedge hclk);
    check("cmd_ready before cmd", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_write = v.wr; cmd_addr = v.addr;
    cmd_burst = v.burst; cmd_len = v.len; hready = 1'b1; hresp = 1'b0;
    @(posedge hclk);

    for (int cyc = 1; cyc <= 60; cyc++) begin
      @(negedge hclk);
      cmd_valid = 1'b0;
      if (wd_pending) begin
        check("hwdata after wr_ack", hwdata, wd_exp);
        wd_pending = 0;
      end
      if (exp_idle) begin
        check("htrans idle after last/err", 32'(htrans), 32'd0);
        exp_idle = 0;
      end
      if (cyc > 1 && !prev_hready && !prev_hresp) begin
        check("hold haddr", haddr, p_haddr);
        check("hold ctrl", 32'({htrans, hwrite, hburst}), 32'({p_htrans, p_hwrite, p_hburst}));
        check("hold hwdata", hwdata, p_hwdata);
      end
      if (rd_valid) begin
        check("rd_data", rd_data, rd_f(tb_addr(v.addr, v.burst, rdn)));
        rdn++;
      end
      if (cmd_done) begin
        done_seen = 1; done_cyc = cyc; done_err = cmd_err;
        break;
      end
      if (cyc == rst_cyc) begin
        hreset = 1'b1;
        break;
      end
      p_haddr = haddr; p_htrans = htrans; p_hwrite = hwrite;
      p_hburst = hburst; p_hwdata = hwdata;

      hready = 1'b1; hresp = 1'b0;
      addr_ph = htrans[1];
      if (addr_ph && v.stall_beat == acc + 1 && stalls < v.stall_n) begin
        hready = 1'b0;
        stalls++;
      end
      if (dp_active && v.err_beat == dp_beat && !err_sent) begin
        hresp = 1'b1; hready = 1'b0; err_sent = 1;
      end
      hrdata  = dp_active ? rd_f(dp_addr) : 32'h0;
      wr_data = v.wd0 + 32'(acc);
      #1;
      if (wr_ack) begin
        ackn++; wd_pending = 1; wd_exp = wr_data;
      end
      prev_hready = hready; prev_hresp = hresp;
      if (hresp) begin
        dp_active = 0; exp_idle = 1;
      end else if (addr_ph && hready) begin
        check("haddr beat", haddr, tb_addr(v.addr, v.burst, acc));
        check("htrans beat", 32'(htrans), (acc == 0) ? 32'd2 : 32'd3);
        addrs.push_back(haddr);
        dp_active = 1; dp_addr = haddr; acc++; dp_beat = acc;
        if (acc == v.exp_beats && v.err_beat == 0) exp_idle = 1;
      end else if (dp_active && hready) begin
        dp_active = 0;
      end
    end

    if (rst_cyc != 0) begin
      hready = 1'b1; hresp = 1'b0;
      #1;
      check("cmd_ready low in reset", 32'(cmd_ready), 32'd0);
      @(posedge hclk);
      @(negedge hclk);
      check("rst htrans", 32'(htrans), 32'd0);
      check("rst haddr", haddr, 32'd0);
      check("rst hwdata", hwdata, 32'd0);
      check("rst rd_data", rd_data, 32'd0);
      check("rst hwrite/hburst", 32'({hwrite, hburst}), 32'd0);
      check("rst pulses", 32'({wr_ack, rd_valid, cmd_done, cmd_err}), 32'd0);
      check("cmd_ready held low", 32'(cmd_ready), 32'd0);
      hreset = 1'b0;
      #1;
      check("cmd_ready after reset", 32'(cmd_ready), 32'd1);
      for (int k = 0; k < 10; k++) begin
        @(negedge hclk);
        if (cmd_done || htrans != 2'b00) bad = 1;
      end
      check("no done/traffic after reset", 32'(bad), 32'd0);
      return;
    end

    if (!done_seen) begin
      n_checks++; n_fail++;
      $display("FAIL cmd_done timeout: got none expected cycle %0d", v.exp_done);
      return;
    end
    check("cmd_done cycle", 32'(done_cyc), 32'(v.exp_done));
    check("cmd_err", 32'(done_err), 32'(v.exp_err));
    check("beats accepted", 32'(acc), 32'(v.exp_beats));
    if (v.exp_beats > 1 && addrs.size() > 1) check("second haddr", addrs[1], v.exp_a1);
    if (addrs.size() > 0) check("last haddr", addrs[addrs.size()-1], v.exp_last);
    else check("last haddr (none)", 32'hFFFF_FFFF, v.exp_last);
    if (v.wr) begin
      check("wr_ack count", 32'(ackn), 32'(v.exp_beats));
      check("rd_valid count", 32'(rdn), 32'd0);
    end else begin
      check("rd_valid count", 32'(rdn), 32'(v.exp_beats));
      check("wr_ack count", 32'(ackn), 32'd0);
    end
  endtask

  initial begin
    vec_t rv;
    hreset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'h0;
    cmd_burst = 3'd0; cmd_len = 5'd0; wr_data = 32'h0; hready = 1'b1;
    hresp = 1'b0; hrdata = 32'h0;

    //        wr    addr           burst len   stall  err wd0            beats a1             last           done err
    vecs[0]  = '{1'b1, 32'h0000_0010, 3'd0, 5'd0,  0, 0, 0, 32'hDEAD_BEEF,  1, 32'h0000_0010, 32'h0000_0010,  3, 1'b0};
    vecs[1]  = '{1'b0, 32'h0000_0020, 3'd3, 5'd0,  0, 0, 0, 32'h0,          4, 32'h0000_0024, 32'h0000_002C,  6, 1'b0};
    vecs[2]  = '{1'b1, 32'h0000_0038, 3'd2, 5'd0,  0, 0, 0, 32'hC0DE_0000,  4, 32'h0000_003C, 32'h0000_0034,  6, 1'b0};
    vecs[3]  = '{1'b0, 32'h0000_0100, 3'd1, 5'd2,  0, 0, 0, 32'h0,          3, 32'h0000_0104, 32'h0000_0108,  5, 1'b0};
    vecs[4]  = '{1'b1, 32'h0000_0040, 3'd1, 5'd31, 0, 0, 0, 32'h1111_0000, 16, 32'h0000_0044, 32'h0000_007C, 18, 1'b0};
    vecs[5]  = '{1'b0, 32'h0000_0074, 3'd4, 5'd0,  0, 0, 0, 32'h0,          8, 32'h0000_0078, 32'h0000_0070, 10, 1'b0};
    vecs[6]  = '{1'b1, 32'hFFFF_FFF8, 3'd3, 5'd0,  0, 0, 0, 32'h2222_0000,  4, 32'hFFFF_FFFC, 32'h0000_0004,  6, 1'b0};
    vecs[7]  = '{1'b1, 32'h0000_000C, 3'd6, 5'd0,  0, 0, 0, 32'h3333_0000, 16, 32'h0000_0010, 32'h0000_0008, 18, 1'b0};
    vecs[8]  = '{1'b0, 32'h0000_0200, 3'd5, 5'd0,  3, 2, 0, 32'h0,          8, 32'h0000_0204, 32'h0000_021C, 12, 1'b0};
    vecs[9]  = '{1'b1, 32'h0000_0400, 3'd7, 5'd0,  0, 0, 5, 32'h4444_0000,  5, 32'h0000_0404, 32'h0000_0410,  8, 1'b1};
    vecs[10] = '{1'b0, 32'h0000_0013, 3'd0, 5'd0,  0, 0, 0, 32'h0,          1, 32'h0000_0010, 32'h0000_0010,  3, 1'b0};

    repeat (3) @(posedge hclk);
    @(negedge hclk);
    hreset = 1'b0;
    #1;
    check("reset htrans", 32'(htrans), 32'd0);
    check("reset haddr", haddr, 32'd0);
    check("reset cmd_ready", 32'(cmd_ready), 32'd1);
    check("reset pulses", 32'({wr_ack, rd_valid, cmd_done, cmd_err}), 32'd0);
    check("fixed hsize/hprot/hmastlock", 32'({hsize, hprot, hmastlock}), 32'({3'b010, 4'b0011, 1'b0}));

    for (int i = 0; i < 10; i++) do_burst(vecs[i], 0);

    // Reset in the middle of an INCR8 read, then a fresh SINGLE command.
    rv = '{1'b0, 32'h0000_0300, 3'd5, 5'd0, 0, 0, 0, 32'h0, 8, 32'h0000_0304, 32'h0000_031C, 10, 1'b0};
    do_burst(rv, 4);
    do_burst(vecs[10], 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
